// File: rtl/dac_upsampler.sv
// Clock-rate sample upsampler: FIFO-buffered low-rate input, one output sample per clock.
// Define DAC_UPSAMPLER_LINEAR_INTERP_EN for linear interpolation; otherwise zero-order hold.
module dac_upsampler #(
    parameter int BW       = 16,
    parameter int OSR_LOG2 = 5,
    parameter int FIFO_AW  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [BW-1:0]        sample_i,
    input  logic                 sample_valid_i,
    output logic                 sample_ready_o,
    output logic [BW-1:0]        dac_o,
    output logic                 underrun_o,
    output logic [FIFO_AW:0]     fifo_level_o
);

    localparam int                DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  DEPTH_L    = (FIFO_AW + 1)'(DEPTH);
    localparam logic [OSR_LOG2-1:0] PHASE_LAST = {OSR_LOG2{1'b1}};

    logic [BW-1:0]        mem_r [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_r;
    logic [FIFO_AW-1:0]   rd_ptr_r;
    logic [FIFO_AW:0]     level_r;
    logic [FIFO_AW:0]     level_next_s;
    logic [OSR_LOG2-1:0]  phase_r;
    logic signed [BW-1:0] cur_r;
    logic signed [BW-1:0] dac_r;
    logic signed [BW-1:0] dac_next_s;
    logic                 underrun_r;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_slot_s;
    logic pop_s;

    assign full_s         = (level_r == DEPTH_L);
    assign empty_s        = (level_r == {(FIFO_AW + 1){1'b0}});
    assign sample_ready_o = !full_s && !rst_i;
    assign push_s         = sample_valid_i && sample_ready_o;
    assign pop_slot_s     = (phase_r == PHASE_LAST);
    assign pop_s          = pop_slot_s && !empty_s;

    // Occupancy update; a simultaneous push and pop leaves the level unchanged.
    always_comb begin
        level_next_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + (FIFO_AW + 1)'(1);
            2'b01:   level_next_s = level_r - (FIFO_AW + 1)'(1);
            default: level_next_s = level_r;
        endcase
    end

    // FIFO storage; writes are gated by ready, which is low during reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= sample_i;
        end
    end

    // Pointers, level, phase, current sample and underrun flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r   <= {FIFO_AW{1'b0}};
            rd_ptr_r   <= {FIFO_AW{1'b0}};
            level_r    <= {(FIFO_AW + 1){1'b0}};
            phase_r    <= {OSR_LOG2{1'b0}};
            cur_r      <= {BW{1'b0}};
            underrun_r <= 1'b0;
        end else begin
            level_r    <= level_next_s;
            phase_r    <= phase_r + OSR_LOG2'(1);
            underrun_r <= pop_slot_s && empty_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
                cur_r    <= mem_r[rd_ptr_r];
            end
        end
    end

`ifdef DAC_UPSAMPLER_LINEAR_INTERP_EN
    localparam int PW = BW + 1 + OSR_LOG2;

    logic signed [BW-1:0] prev_r;
    logic signed [PW-1:0] diff_s;
    logic signed [PW-1:0] phase_ext_s;
    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] step_s;
    logic signed [PW-1:0] sum_s;

    // prev follows cur at every pop slot, including empty ones, so the ramp settles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_r <= {BW{1'b0}};
        end else if (pop_slot_s) begin
            prev_r <= cur_r;
        end else begin
            prev_r <= prev_r;
        end
    end

    // Interpolate prev + floor((cur - prev) * phase / N); the result lies between prev and cur.
    always_comb begin
        diff_s      = PW'(cur_r) - PW'(prev_r);
        phase_ext_s = $signed({{(PW - OSR_LOG2){1'b0}}, phase_r});
        prod_s      = diff_s * phase_ext_s;
        step_s      = prod_s >>> OSR_LOG2;
        sum_s       = PW'(prev_r) + step_s;
        dac_next_s  = sum_s[BW-1:0];
    end
`else
    // Zero-order hold: output follows the current sample directly.
    always_comb begin
        dac_next_s = cur_r;
    end
`endif

    // Registered output sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dac_r <= {BW{1'b0}};
        end else begin
            dac_r <= dac_next_s;
        end
    end

    assign dac_o        = dac_r;
    assign underrun_o   = underrun_r;
    assign fifo_level_o = level_r;

endmodule

// File: tb/tb_dac_upsampler.sv
// Scoreboard bench for dac_upsampler with OSR_LOG2=2, FIFO_AW=2; expectations follow the
// DAC_UPSAMPLER_LINEAR_INTERP_EN setting of the build.
module tb_dac_upsampler;

    logic               clk;
    logic               rst;
    logic signed [15:0] sample;
    logic               valid;
    logic               ready;
    logic [15:0]        dac;
    logic               underrun;
    logic [2:0]         level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string              name;
        logic signed [15:0] dac;
        logic               und;
        logic [2:0]         lvl;
        logic               rdy;
    } exp_t;

    exp_t exp_q[$];

    dac_upsampler #(.BW(16), .OSR_LOG2(2), .FIFO_AW(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sample_i       (sample),
        .sample_valid_i (valid),
        .sample_ready_o (ready),
        .dac_o          (dac),
        .underrun_o     (underrun),
        .fifo_level_o   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // Monitor: compare the DUT outputs against the oldest expectation at each falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ($signed(dac) !== e.dac) begin
                errors++;
                $display("FAIL %s dac: got %0d, required %0d", e.name, $signed(dac), e.dac);
            end
            checks++;
            if (underrun !== e.und) begin
                errors++;
                $display("FAIL %s underrun: got %b, required %b", e.name, underrun, e.und);
            end
            checks++;
            if (level !== e.lvl) begin
                errors++;
                $display("FAIL %s level: got %0d, required %0d", e.name, level, e.lvl);
            end
            checks++;
            if (ready !== e.rdy) begin
                errors++;
                $display("FAIL %s ready: got %b, required %b", e.name, ready, e.rdy);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic v, input int s,
                        input int ed, input logic eu, input int el, input logic er);
        exp_t e;
        rst    = r;
        valid  = v;
        sample = 16'(s);
        e.name = nm;
        e.dac  = 16'(ed);
        e.und  = eu;
        e.lvl  = 3'(el);
        e.rdy  = er;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic int lvl_a(input int k);
        if (k == 0)       return 0;
        else if (k <= 3)  return k;
        else if (k == 4)  return 3;
        else if (k <= 7)  return 4;
        else if (k <= 11) return 3;
        else if (k <= 15) return 2;
        else if (k <= 19) return 1;
        else              return 0;
    endfunction

    function automatic int dac_a(input int k);
`ifdef DAC_UPSAMPLER_LINEAR_INTERP_EN
        if (k <= 4)       return 0;
        else if (k <= 24) return 100 * ((k - 5) / 4) + 25 * ((k - 5) % 4);
        else              return 500;
`else
        if (k <= 4)       return 0;
        else if (k <= 24) return 100 * ((k - 5) / 4 + 1);
        else              return 500;
`endif
    endfunction

    function automatic int dac_b(input int k);
`ifdef DAC_UPSAMPLER_LINEAR_INTERP_EN
        if (k <= 4)       return 0;
        else if (k <= 8)  return 250 * (k - 5);
        else if (k == 9)  return 1000;
        else if (k == 10) return 250;
        else if (k == 11) return -500;
        else if (k == 12) return -1250;
        else              return -2000;
`else
        if (k <= 4)       return 0;
        else if (k <= 8)  return 1000;
        else              return -2000;
`endif
    endfunction

    function automatic int dac_c(input int k);
`ifdef DAC_UPSAMPLER_LINEAR_INTERP_EN
        if (k <= 4)       return 0;
        else if (k <= 8)  return -(k - 5);
        else              return -3;
`else
        if (k <= 4)       return 0;
        else              return -3;
`endif
    endfunction

    initial begin
        rst    = 1'b1;
        valid  = 1'b1;
        sample = 16'sd7;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            step("reset", 1'b1, 1'b1, 7, 0, 1'b0, 0, 1'b0);
        end

        // Fill to full, drain to empty, underrun pulses, then a mid-run reset at k=32.
        for (int k = 0; k <= 32; k++) begin
            step("fill", (k == 32), (k < 8), (k < 5) ? 100 * (k + 1) : 600,
                 dac_a(k), (k >= 24) && (k % 4 == 0), lvl_a(k),
                 (k != 32) && !((k >= 5) && (k <= 7)));
        end

        // 1000 then -2000, then reset at k=20.
        for (int k = 0; k <= 20; k++) begin
            step("step", (k == 20), (k == 0) || (k == 4), (k == 0) ? 1000 : -2000,
                 dac_b(k), (k >= 12) && (k % 4 == 0),
                 ((k >= 1 && k <= 3) || (k >= 5 && k <= 7)) ? 1 : 0, (k != 20));
        end

        // Small negative sample exercising floor rounding.
        for (int k = 0; k <= 13; k++) begin
            step("neg", 1'b0, (k == 0), -3, dac_c(k), (k >= 8) && (k % 4 == 0),
                 (k >= 1 && k <= 3) ? 1 : 0, 1'b1);
        end

        valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
